// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (ctrl + data bundles) with stall, flush, bubble insertion and optional skid entry; 1-cycle latency.
// Backpressure: SKID=0 gives ready combinationally from ready_i, SKID=1 gives registered ready (~skid_v); stall forces ready low.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_xfer;
    logic              out_xfer;
    logic [CNT_W-1:0]  cnt_q;

    assign valid_o  = main_v & ~stall_i;
    assign ctrl_o   = main_v ? main_ctrl : '0;
    assign data_o   = main_data;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_v;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            assign ready_o = ~rst_i & ~stall_i & ~skid_v;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    main_v    <= 1'b0;
                    main_ctrl <= '0;
                    main_data <= '0;
                    skid_v    <= 1'b0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else if (flush_i) begin
                    main_v    <= 1'b0;
                    main_ctrl <= '0;
                    skid_v    <= 1'b0;
                    skid_ctrl <= '0;
                end else if (!stall_i) begin
                    if (!main_v || out_xfer) begin
                        // The skid beat is older than anything arriving now, so it advances first.
                        if (skid_v) begin
                            main_v    <= 1'b1;
                            main_ctrl <= skid_ctrl;
                            main_data <= skid_data;
                            skid_v    <= in_xfer;
                            skid_ctrl <= in_xfer ? ctrl_i : '0;
                            if (in_xfer) begin
                                skid_data <= data_i;
                            end
                        end else begin
                            main_v    <= in_xfer;
                            main_ctrl <= in_xfer ? ctrl_i : '0;
                            if (in_xfer) begin
                                main_data <= data_i;
                            end
                        end
                    end else if (in_xfer) begin
                        skid_v    <= 1'b1;
                        skid_ctrl <= ctrl_i;
                        skid_data <= data_i;
                    end
                end
            end
        end else begin : g_single
            assign ready_o = ~rst_i & ~stall_i & (~main_v | ready_i);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    main_v    <= 1'b0;
                    main_ctrl <= '0;
                    main_data <= '0;
                end else if (flush_i) begin
                    main_v    <= 1'b0;
                    main_ctrl <= '0;
                end else if (!stall_i) begin
                    if (in_xfer) begin
                        main_v    <= 1'b1;
                        main_ctrl <= ctrl_i;
                        main_data <= data_i;
                    end else if (out_xfer) begin
                        main_v    <= 1'b0;
                        main_ctrl <= '0;
                    end
                end
            end
        end
    endgenerate

    // Counts hazard holds and downstream back-pressure alike; sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if ((stall_i || (valid_o && !ready_i)) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance share the same stimulus.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_i;
    logic        stall_i;
    logic        flush_i;
    logic        cnt_clr_i;
    logic [7:0]  ctrl_i;
    logic [95:0] data_i;

    logic        rdy0, v0;
    logic [7:0]  c0;
    logic [95:0] d0;
    logic [15:0] cnt0;
    logic        rdy1, v1;
    logic [7:0]  c1;
    logic [95:0] d1;
    logic [3:0]  cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(16)) u_d0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy0),
        .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v0), .ready_i(ready_i),
        .ctrl_o(c0), .data_o(d0), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(cnt0)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(4)) u_d1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy1),
        .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v1), .ready_i(ready_i),
        .ctrl_o(c1), .data_o(d1), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sel;
        logic        vi;
        logic [7:0]  ci;
        logic        ri;
        logic        st;
        logic        fl;
        logic        clr;
        logic        ev;
        logic [7:0]  ec;
        logic        er;
        logic [15:0] ecnt;
        logic        cd;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int sel, input logic vi, input logic [7:0] ci,
                                input logic ri, input logic st, input logic fl, input logic clr,
                                input logic ev, input logic [7:0] ec, input logic er,
                                input logic [15:0] ecnt, input logic cd = 1'b0,
                                input logic [7:0] ed = 8'h00);
        vec_t r;
        r.sel = sel; r.vi = vi; r.ci = ci; r.ri = ri; r.st = st; r.fl = fl; r.clr = clr;
        r.ev = ev; r.ec = ec; r.er = er; r.ecnt = ecnt; r.cd = cd; r.ed = ed;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic r,
                         input logic st, input logic fl, input logic clr);
        valid_i   = v;
        ctrl_i    = c;
        data_i    = {12{c}};
        ready_i   = r;
        stall_i   = st;
        flush_i   = fl;
        cnt_clr_i = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // SKID=0 throughput, ready_i toggling 1,0,1 with combinational ready
        tbl.push_back(mk(0, 1, 8'h31, 1, 0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 8'h32, 0, 0, 0, 0, 1, 8'h31, 0, 0));
        tbl.push_back(mk(0, 1, 8'h32, 1, 0, 0, 0, 1, 8'h31, 1, 1, 1, 8'h31));
        tbl.push_back(mk(0, 1, 8'h33, 1, 0, 0, 0, 1, 8'h32, 1, 1, 1, 8'h32));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h33, 1, 1, 1, 8'h33));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 1));
        // flush + clear both instances, nothing checked
        tbl.push_back(mk(2, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, 0));
        // SKID=1 stream
        tbl.push_back(mk(1, 1, 8'h11, 1, 0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 8'h12, 1, 0, 0, 0, 1, 8'h11, 1, 0, 1, 8'h11));
        tbl.push_back(mk(1, 1, 8'h13, 1, 0, 0, 0, 1, 8'h12, 1, 0, 1, 8'h12));
        tbl.push_back(mk(1, 1, 8'h14, 1, 0, 0, 0, 1, 8'h13, 1, 0, 1, 8'h13));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h14, 1, 0, 1, 8'h14));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 0));
        // SKID=1 back-pressure: A in main, B in skid, C held upstream
        tbl.push_back(mk(1, 1, 8'h21, 0, 0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 8'h22, 0, 0, 0, 0, 1, 8'h21, 1, 0));
        tbl.push_back(mk(1, 1, 8'h23, 0, 0, 0, 0, 1, 8'h21, 0, 1));
        tbl.push_back(mk(1, 1, 8'h23, 0, 0, 0, 0, 1, 8'h21, 0, 2));
        tbl.push_back(mk(1, 1, 8'h23, 1, 0, 0, 0, 1, 8'h21, 0, 3, 1, 8'h21));
        tbl.push_back(mk(1, 1, 8'h23, 1, 0, 0, 0, 1, 8'h22, 1, 3, 1, 8'h22));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h23, 1, 3, 1, 8'h23));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 1, 3));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 0));
        // flush overrides stall; data survives; beat accepted during flush is dropped
        tbl.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 8'hEE, 0, 1, 1, 0, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 1, 1, 8'hFF));
        tbl.push_back(mk(1, 1, 8'hEE, 0, 0, 1, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0));
        // stall hold for 4 cycles
        tbl.push_back(mk(1, 1, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 8'h66, 1, 1, 0, 0, 0, 8'h5A, 0, 0, 1, 8'h5A));
        tbl.push_back(mk(1, 1, 8'h66, 1, 1, 0, 0, 0, 8'h5A, 0, 1, 1, 8'h5A));
        tbl.push_back(mk(1, 1, 8'h66, 1, 1, 0, 0, 0, 8'h5A, 0, 2, 1, 8'h5A));
        tbl.push_back(mk(1, 1, 8'h66, 1, 1, 0, 0, 0, 8'h5A, 0, 3, 1, 8'h5A));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h5A, 1, 4, 1, 8'h5A));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 4));

        #1;
        chk("reset d1 valid_o", {95'b0, v1}, 96'd0);
        chk("reset d1 ctrl_o", {88'b0, c1}, 96'd0);
        chk("reset d1 data_o", d1, 96'd0);
        chk("reset d1 ready_o", {95'b0, rdy1}, 96'd0);
        chk("reset d0 ready_o", {95'b0, rdy0}, 96'd0);
        chk("reset d1 stall_cnt", {92'b0, cnt1}, 96'd0);
        tick();
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].vi, tbl[i].ci, tbl[i].ri, tbl[i].st, tbl[i].fl, tbl[i].clr);
            #3;
            if (tbl[i].sel == 0) begin
                chk($sformatf("row%0d d0 valid_o", i), {95'b0, v0}, {95'b0, tbl[i].ev});
                chk($sformatf("row%0d d0 ctrl_o", i), {88'b0, c0}, {88'b0, tbl[i].ec});
                chk($sformatf("row%0d d0 ready_o", i), {95'b0, rdy0}, {95'b0, tbl[i].er});
                chk($sformatf("row%0d d0 stall_cnt", i), {80'b0, cnt0}, {80'b0, tbl[i].ecnt});
                if (tbl[i].cd) chk($sformatf("row%0d d0 data_o", i), d0, {12{tbl[i].ed}});
            end else if (tbl[i].sel == 1) begin
                chk($sformatf("row%0d d1 valid_o", i), {95'b0, v1}, {95'b0, tbl[i].ev});
                chk($sformatf("row%0d d1 ctrl_o", i), {88'b0, c1}, {88'b0, tbl[i].ec});
                chk($sformatf("row%0d d1 ready_o", i), {95'b0, rdy1}, {95'b0, tbl[i].er});
                chk($sformatf("row%0d d1 stall_cnt", i), {92'b0, cnt1}, {80'b0, tbl[i].ecnt});
                if (tbl[i].cd) chk($sformatf("row%0d d1 data_o", i), d1, {12{tbl[i].ed}});
            end
            tick();
        end

        // counter saturation: 20 cycles of back-pressure on a held beat
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("sat d1 cnt at 14", {92'b0, cnt1}, 96'd14);
            if (k == 16) chk("sat d1 cnt at 16", {92'b0, cnt1}, 96'd15);
        end
        #2;
        chk("sat d1 cnt final", {92'b0, cnt1}, 96'd15);
        chk("sat d0 cnt final", {80'b0, cnt0}, 96'd20);
        chk("sat d1 valid_o", {95'b0, v1}, 96'd1);
        chk("sat d1 ctrl_o", {88'b0, c1}, 96'h77);

        // async reset mid-cycle, no clock edge in between
        rst = 1'b1;
        #1;
        chk("arst d1 valid_o", {95'b0, v1}, 96'd0);
        chk("arst d1 ctrl_o", {88'b0, c1}, 96'd0);
        chk("arst d1 data_o", d1, 96'd0);
        chk("arst d1 ready_o", {95'b0, rdy1}, 96'd0);
        chk("arst d1 stall_cnt", {92'b0, cnt1}, 96'd0);
        chk("arst d0 valid_o", {95'b0, v0}, 96'd0);
        chk("arst d0 stall_cnt", {80'b0, cnt0}, 96'd0);
        tick();
        rst = 1'b0;
        #3;
        chk("post-reset d1 ready_o", {95'b0, rdy1}, 96'd1);
        chk("post-reset d0 ready_o", {95'b0, rdy0}, 96'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
